transmitter: RTL and testbench

8N1 UART transmitter with a 4-entry byte FIFO, the transmit-side counterpart of the serial receiver on the FPGA-to-host link. Game logic pushes bytes with a one-cycle `send` strobe whenever `ready` is high. The block serialises them LSB-first onto `out` at `clock_per_bit` clocks per bit. Frames are sent back-to-back while the FIFO holds data, and the line idles high otherwise.

---
 rtl/transmitter.sv | 146 ++++++++++++++
 tb/tb_transmitter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// transmitter: 8N1 UART transmitter with a small byte FIFO.
// Bytes pushed with send && ready are queued, then serialised LSB-first
// on out at clock_per_bit clocks per bit; frames run back-to-back while
// the FIFO holds data, and the line idles high otherwise.
module transmitter #(
    parameter int unsigned clock_per_bit   = 217,
    parameter int unsigned fifo_depth_log2 = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     send,
    input  logic [7:0]               send_data,
    output logic                     ready,
    output logic                     busy,
    output logic [fifo_depth_log2:0] fifo_count,
    output logic                     out
);

    localparam int unsigned DEPTH = 1 << fifo_depth_log2;
    localparam logic [11:0] BAUD_LAST = 12'(clock_per_bit - 1);
    localparam logic [fifo_depth_log2:0] CNT_FULL = (fifo_depth_log2 + 1)'(DEPTH);
    localparam logic [fifo_depth_log2:0] CNT_ONE = (fifo_depth_log2 + 1)'(1);
    localparam logic [fifo_depth_log2-1:0] PTR_ONE = fifo_depth_log2'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]                 mem [DEPTH];
    logic [fifo_depth_log2-1:0] wr_ptr;
    logic [fifo_depth_log2-1:0] rd_ptr;
    logic [fifo_depth_log2:0]   count;

    state_t      state;
    logic [11:0] baud_cnt;
    logic [7:0]  sh;
    logic [2:0]  bit_idx;

    logic fifo_empty;
    logic baud_tc;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    assign baud_tc    = (baud_cnt == BAUD_LAST);
    assign ready      = (count != CNT_FULL);
    assign push       = send && ready;
    // The serialiser takes the head either from IDLE or straight out of STOP
    assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_tc));

    assign busy       = (state != IDLE) || !fifo_empty;
    assign fifo_count = count;

    // FIFO storage write; reset blocks writes so a reset edge changes nothing here
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= send_data;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Serialiser FSM with registered line output
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            sh       <= '0;
            bit_idx  <= '0;
            out      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    out      <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        sh    <= mem[rd_ptr];
                        out   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        out      <= sh[0];
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            out   <= 1'b1;
                            state <= STOP;
                        end else begin
                            sh      <= sh >> 1;
                            out     <= sh[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            sh    <= mem[rd_ptr];
                            out   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: scoreboard bench for the UART transmitter.
// Stimulus queues expected bytes; a line-level receiver model decodes
// frames from out and compares them against the queue.
module tb_transmitter;

    localparam int unsigned CPB = 217;
    localparam int unsigned FDL = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         send = 1'b0;
    logic [7:0]   send_data = 8'h00;
    logic         ready;
    logic         busy;
    logic [FDL:0] fifo_count;
    logic         out;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    logic [7:0]  exp_q[$];
    int unsigned start_cyc[$];

    transmitter #(
        .clock_per_bit  (CPB),
        .fifo_depth_log2(FDL)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .send_data (send_data),
        .ready     (ready),
        .busy      (busy),
        .fifo_count(fifo_count),
        .out       (out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Receiver model: detects a start bit, samples mid-bit, compares with the queue
    logic        m_active = 1'b0;
    int unsigned m_cnt = 0;
    logic [7:0]  m_byte;
    always @(negedge clock) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (out == 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                start_cyc.push_back(cyc);
            end
        end else begin
            m_cnt++;
            if (m_cnt % CPB == CPB / 2) begin
                if (m_cnt / CPB == 0) begin
                    check("start_bit", {31'd0, out}, 32'd0);
                end else if (m_cnt / CPB <= 8) begin
                    m_byte = {out, m_byte[7:1]};
                end else begin
                    check("stop_bit", {31'd0, out}, 32'd1);
                    m_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", {24'd0, m_byte}, 32'hFFFF_FFFF);
                    end else begin
                        check("frame_byte", {24'd0, m_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0]  fb;
        int unsigned n0;

        // Reset values
        step(3);
        check("rst_out", {31'd0, out}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        reset = 1'b0;
        step(2);

        // Single byte 0xA5 with bit-boundary checks
        send = 1'b1;
        send_data = 8'hA5;
        exp_q.push_back(8'hA5);
        step(1);
        send = 1'b0;
        check("single_count_after_push", {29'd0, fifo_count}, 32'd1);
        check("single_out_still_idle", {31'd0, out}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        step(1);
        check("single_count_after_pop", {29'd0, fifo_count}, 32'd0);
        fb = 10'b1_1010_0101_0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bit%0d_first", k), {31'd0, out}, {31'd0, fb[k]});
            step(CPB - 1);
            check($sformatf("bit%0d_last", k), {31'd0, out}, {31'd0, fb[k]});
            if (k == 9) begin
                check("single_busy_last_cycle", {31'd0, busy}, 32'd1);
            end
            step(1);
        end
        check("single_out_after", {31'd0, out}, 32'd1);
        check("single_busy_after", {31'd0, busy}, 32'd0);
        step(5);
        check("single_queue_empty", exp_q.size(), 32'd0);

        // Burst overflow with a rejected push on the full-FIFO pop edge
        start_cyc.delete();
        send = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_data = 8'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            step(1);
            if (i == 5) begin
                check("burst_ready_full", {31'd0, ready}, 32'd0);
                check("burst_count_full", {29'd0, fifo_count}, 32'd4);
            end
        end
        send = 1'b0;
        check("burst_drop_count", {29'd0, fifo_count}, 32'd4);
        step(10 * CPB - 5);
        check("full_ready_before_pop", {31'd0, ready}, 32'd0);
        send = 1'b1;
        send_data = 8'h77;
        step(1);
        send = 1'b0;
        check("full_ready_after_pop", {31'd0, ready}, 32'd1);
        check("full_count_after_pop", {29'd0, fifo_count}, 32'd3);
        check("full_out_start", {31'd0, out}, 32'd0);
        wait_idle(60 * CPB);
        step(5);
        check("burst_frames", start_cyc.size(), 32'd5);
        if (start_cyc.size() >= 5) begin
            for (int i = 1; i < 5; i++) begin
                check($sformatf("burst_gap%0d", i), start_cyc[i] - start_cyc[i-1], 10 * CPB);
            end
        end
        check("burst_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-frame during data bit 3 of 0xFF with two bytes queued
        send = 1'b1;
        send_data = 8'hFF;
        step(1);
        send_data = 8'h12;
        step(1);
        send_data = 8'h34;
        step(1);
        send = 1'b0;
        check("midrst_count", {29'd0, fifo_count}, 32'd2);
        step(4 * CPB + 9);
        check("midrst_bit3", {31'd0, out}, 32'd1);
        reset = 1'b1;
        step(1);
        check("midrst_out", {31'd0, out}, 32'd1);
        check("midrst_count_after", {29'd0, fifo_count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        reset = 1'b0;
        n0 = start_cyc.size();
        step(3 * CPB);
        check("midrst_no_frames", start_cyc.size(), n0);
        check("midrst_line_idle", {31'd0, out}, 32'd1);

        // Loopback of four bytes through the receiver model
        send = 1'b1;
        foreach (fb[i]) begin end
        send_data = 8'h00; exp_q.push_back(8'h00); step(1);
        send_data = 8'hFF; exp_q.push_back(8'hFF); step(1);
        send_data = 8'h55; exp_q.push_back(8'h55); step(1);
        send_data = 8'h3C; exp_q.push_back(8'h3C); step(1);
        send = 1'b0;
        wait_idle(50 * CPB);
        step(5);
        check("loop_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
